dsp_ccff_loader: RTL

- Configuration-chain loader that sits directly upstream of the DSP physical tile's configuration chain and drives its ccff_head / config_enable.
- Accepts the 85-bit DSP mode image as a stream of parallel words over a valid/ready handshake and buffers the complete image.
- Serialises the image into the chain on prog_clock, one bit per cycle.
- Optionally recirculates the chain through ccff_tail once more to read back and check the loaded image without destroying it.

---
 rtl/dsp_cfg_pkg.sv | 16 +
 rtl/dsp_ccff_shift_ctrl.sv | 67 ++++++
 rtl/dsp_ccff_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dsp_cfg_pkg.sv
// Shared constants and state encoding for the DSP configuration-chain loader.
package dsp_cfg_pkg;

    localparam int unsigned DSP_MODE_BITS = 85;
    localparam int unsigned CFG_WORD_W    = 32;
    localparam int unsigned CFG_NUM_WORDS = (DSP_MODE_BITS + CFG_WORD_W - 1) / CFG_WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SHIFT,
        VERIFY,
        DONE
    } ldr_state_t;

endpackage

// File: rtl/dsp_ccff_shift_ctrl.sv
// Bit counter, chain head driver and readback comparator for the loader.
module dsp_ccff_shift_ctrl #(
    parameter int unsigned CHAIN_LEN = 85
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_d_i,
    input  logic                 verify_d_i,
    input  logic                 verify_q_i,
    input  logic                 phase_start_i,
    input  logic                 abort_i,
    input  logic                 err_clr_i,
    input  logic [CHAIN_LEN-1:0] image_i,
    input  logic                 ccff_tail_i,
    output logic                 last_bit_c,
    output logic                 config_enable_o,
    output logic                 ccff_head_o,
    output logic                 error_o
);

    localparam int unsigned BCNT_W = $clog2(CHAIN_LEN);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [BCNT_W-1:0] cur_idx_c, nxt_idx_c;
    logic              en_q, en_d;
    logic              head_q, head_d;
    logic              err_q, err_d;

    // Image is sent MSB first so image[k] ends up in chain position k.
    always_comb begin
        bcnt_d = '0;
        if ((shift_d_i || verify_d_i) && !phase_start_i) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
        end
        en_d      = shift_d_i | verify_d_i;
        nxt_idx_c = BCNT_W'(CHAIN_LEN - 1) - bcnt_d;
        cur_idx_c = BCNT_W'(CHAIN_LEN - 1) - bcnt_q;
        head_d    = shift_d_i ? image_i[nxt_idx_c] : 1'b0;
        err_d     = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end else if (verify_q_i && !abort_i && (ccff_tail_i != image_i[cur_idx_c])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            en_q   <= 1'b0;
            head_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            en_q   <= en_d;
            head_q <= head_d;
            err_q  <= err_d;
        end
    end

    assign last_bit_c      = (bcnt_q == BCNT_W'(CHAIN_LEN - 1));
    assign config_enable_o = en_q;
    // During readback the tail is fed straight back so the chain keeps its content.
    assign ccff_head_o     = verify_q_i ? ccff_tail_i : head_q;
    assign error_o         = err_q;

endmodule

// File: rtl/dsp_ccff_loader.sv
// Collects a DSP mode image from parallel words and shifts it into the
// configuration chain, with an optional non-destructive readback pass.
module dsp_ccff_loader
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DSP_MODE_BITS,
    parameter int unsigned WORD_W    = CFG_WORD_W
) (
    input  logic              prog_clock,
    input  logic              prog_reset_n,
    input  logic [WORD_W-1:0] cfg_word_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic              verify_en_i,
    input  logic              abort_i,
    output logic              config_enable_o,
    output logic              ccff_head_o,
    input  logic              ccff_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);

    ldr_state_t           state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CHAIN_LEN-1:0] image_q, image_d;
    logic                 verify_q, verify_d;
    logic                 ready_q, busy_q, done_q;
    logic                 accept_c, err_clr_c, last_bit_c;

    // Abort wins over a word offered in the same cycle.
    assign accept_c = cfg_valid_i & ready_q & ~abort_i;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        verify_d  = verify_q;
        err_clr_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    verify_d  = verify_en_i;
                    err_clr_c = 1'b1;
                    wcnt_d    = WCNT_W'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (abort_i) begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else if (accept_c) begin
                    if (wcnt_q == WCNT_W'(NUM_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = SHIFT;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_bit_c) begin
                    state_d = verify_q ? VERIFY : DONE;
                end
            end
            VERIFY: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_bit_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word j lands in image bits [j*WORD_W +: WORD_W]; bits past the chain are dropped.
    always_comb begin
        image_d = image_q;
        for (int unsigned b = 0; b < CHAIN_LEN; b++) begin
            if (accept_c && ((b / WORD_W) == 32'(wcnt_q))) begin
                image_d[b] = cfg_word_i[b % WORD_W];
            end
        end
    end

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            image_q  <= '0;
            verify_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            image_q  <= image_d;
            verify_q <= verify_d;
            ready_q  <= (state_d == IDLE) || (state_d == COLLECT);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    dsp_ccff_shift_ctrl #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift_ctrl (
        .clk             (prog_clock),
        .rst_n           (prog_reset_n),
        .shift_d_i       (state_d == SHIFT),
        .verify_d_i      (state_d == VERIFY),
        .verify_q_i      (state_q == VERIFY),
        .phase_start_i   (state_d != state_q),
        .abort_i         (abort_i),
        .err_clr_i       (err_clr_c),
        .image_i         (image_d),
        .ccff_tail_i     (ccff_tail_i),
        .last_bit_c      (last_bit_c),
        .config_enable_o (config_enable_o),
        .ccff_head_o     (ccff_head_o),
        .error_o         (error_o)
    );

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
